// File: rtl/conv_pe_sequencer.sv
// PE-array sequencer: fire, time the MAC window, collect masked results, stream one OFM word per pixel.
// Optional completion watchdog enabled by defining SEQ_WATCHDOG_EN.
module conv_pe_sequencer #(
   parameter int NUM_PE     = 16,
   parameter int DATA_W     = 8,
   parameter int MAC_CYCLES = 35,
   parameter int PIX_CNT_W  = 16,
   parameter int TIMEOUT    = 1023
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [PIX_CNT_W-1:0]       num_pixels,
   input  logic [NUM_PE-1:0]          pe_mask,
   output logic [NUM_PE-1:0]          PE_en,
   output logic [NUM_PE-1:0]          PE_finish,
   input  logic [NUM_PE-1:0]          valid,
   input  logic [NUM_PE*DATA_W-1:0]   pe_ofm,
   output logic [NUM_PE*DATA_W-1:0]   ofm_data,
   output logic                       ofm_valid,
   input  logic                       ofm_ready,
   output logic [PIX_CNT_W-1:0]       ofm_pix,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [2:0]                 dbg_state
);

   // Downstream handshake: a word transfers on any cycle where ofm_valid && ofm_ready;
   // ofm_valid never drops and ofm_data/ofm_pix never change until that transfer.

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FIRE   = 3'd1,
      S_MAC    = 3'd2,
      S_FINISH = 3'd3,
      S_OUT    = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // One counter times the MAC window and, with the watchdog, the FINISH wait.
   localparam int CNT_MAX = (MAC_CYCLES > TIMEOUT) ? MAC_CYCLES : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [PIX_CNT_W-1:0]       num_q, num_d;
   logic [NUM_PE-1:0]          mask_q, mask_d;
   logic [PIX_CNT_W-1:0]       pix_q, pix_d;
   logic [NUM_PE*DATA_W-1:0]   data_q, data_d;
   logic [NUM_PE*DATA_W-1:0]   masked_ofm;
   logic                       all_valid;
`ifdef SEQ_WATCHDOG_EN
   logic                       err_q, err_d;
`endif

   for (genvar k = 0; k < NUM_PE; k++) begin : g_mask
      assign masked_ofm[k*DATA_W +: DATA_W] = mask_q[k] ? pe_ofm[k*DATA_W +: DATA_W] : '0;
   end

   assign all_valid = ((valid & mask_q) == mask_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         num_q   <= '0;
         mask_q  <= '0;
         pix_q   <= '0;
         data_q  <= '0;
`ifdef SEQ_WATCHDOG_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         mask_q  <= mask_d;
         pix_q   <= pix_d;
         data_q  <= data_d;
`ifdef SEQ_WATCHDOG_EN
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      num_d     = num_q;
      mask_d    = mask_q;
      pix_d     = pix_q;
      data_d    = data_q;
`ifdef SEQ_WATCHDOG_EN
      err_d     = err_q;
`endif
      PE_en     = '0;
      PE_finish = '0;
      ofm_valid = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_d  = num_pixels;
               mask_d = pe_mask;
               pix_d  = '0;
`ifdef SEQ_WATCHDOG_EN
               err_d  = 1'b0;
`endif
               state_d = (num_pixels == '0) ? S_DONE : S_FIRE;
            end
         end
         S_FIRE: begin
            PE_en   = mask_q;
            cnt_d   = CNT_W'(MAC_CYCLES - 1);
            state_d = S_MAC;
         end
         S_MAC: begin
            if (cnt_q == '0) begin
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_FINISH: begin
            PE_finish = mask_q;
            if (all_valid) begin
               data_d  = masked_ofm;
               state_d = S_OUT;
`ifdef SEQ_WATCHDOG_EN
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
         S_OUT: begin
            ofm_valid = 1'b1;
            if (ofm_ready) begin
               if (pix_q == num_q - PIX_CNT_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  pix_d   = pix_q + PIX_CNT_W'(1);
                  state_d = S_FIRE;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ofm_data  = data_q;
   assign ofm_pix   = pix_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;
`ifdef SEQ_WATCHDOG_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Bench for conv_pe_sequencer: table of runs with hand-computed results plus reset/zero-length/abort/watchdog sequences.
module tb_conv_pe_sequencer;

   localparam int MACC = 35;
   localparam int TMO  = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [15:0]   num_pixels;
   logic [15:0]   pe_mask;
   logic [15:0]   PE_en;
   logic [15:0]   PE_finish;
   logic [15:0]   valid;
   logic [127:0]  pe_ofm;
   logic [127:0]  ofm_data;
   logic          ofm_valid;
   logic          ofm_ready;
   logic [15:0]   ofm_pix;
   logic          busy;
   logic          done;
   logic          err;
   logic [2:0]    dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   conv_pe_sequencer #(
      .NUM_PE(16), .DATA_W(8), .MAC_CYCLES(MACC), .PIX_CNT_W(16), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .num_pixels(num_pixels), .pe_mask(pe_mask),
      .PE_en(PE_en), .PE_finish(PE_finish), .valid(valid), .pe_ofm(pe_ofm),
      .ofm_data(ofm_data), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm_pix(ofm_pix),
      .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           n;
      logic [15:0]  mask;
      logic [127:0] ofm;
      logic [15:0]  vpat;
      int           vdelay;
      int           rdelay;
      logic [127:0] exp_data;
      int           exp_period;
   } run_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drives one run; start stays high with junk operands to prove it is ignored mid-run.
   task automatic run(input run_t r);
      int cyc = 0, pulses = 0, last_en = -1, fin = 0, ov = 0, hs = 0, dones = 0;
      int first_en = -1, first_fin = -1, first_ov = -1;
      bit prev_hs = 1'b0;
      start = 1'b1; num_pixels = 16'(r.n); pe_mask = r.mask; pe_ofm = r.ofm;
      valid = '0; ofm_ready = 1'b1;
      step();
      num_pixels = 16'd0; pe_mask = ~r.mask;
      while (dones == 0 && cyc < 3000) begin
         cyc++;
         if (cyc == 1) begin
            chk("busy_run", busy, 1);
            chk("err_cleared", err, 0);
         end
         if (PE_en != '0) begin
            pulses++;
            chk("pe_en", PE_en, r.mask);
            if (first_en < 0) first_en = cyc;
            if (last_en >= 0) chk("period", cyc - last_en, r.exp_period);
            last_en = cyc;
         end
         if (PE_finish != '0) begin
            fin++;
            if (first_fin < 0) first_fin = cyc;
            if (fin == 1) chk("pe_finish", PE_finish, r.mask);
         end else begin
            fin = 0;
         end
         valid = (fin > r.vdelay) ? r.vpat : 16'h0000;
         if (ofm_valid) begin
            ov++;
            if (first_ov < 0) first_ov = cyc;
            chk("ofm_data", ofm_data, r.exp_data);
            chk("ofm_pix", ofm_pix, hs);
            if (ov == 1) begin
               chk("finish_in_out", PE_finish, 0);
               chk("no_en_in_out", PE_en, 0);
            end
            pe_ofm = ~r.ofm;
            ofm_ready = (ov > r.rdelay);
         end else begin
            ov = 0;
            pe_ofm = r.ofm;
            ofm_ready = 1'b1;
         end
         if (done) begin
            dones++;
            chk("done_after_hs", prev_hs, 1);
            start = 1'b0;
         end
         prev_hs = ofm_valid && ofm_ready;
         if (prev_hs) hs++;
         step();
      end
      if (dones == 0) begin
         n_checks++; n_fail++;
         $display("FAIL run_timeout: got no done expected done within 3000 cycles");
      end
      chk("first_en_cyc", first_en, 1);
      chk("first_fin_cyc", first_fin, MACC + 2);
      chk("first_ov_cyc", first_ov, MACC + 3 + r.vdelay);
      chk("pulses", pulses, r.n);
      chk("handshakes", hs, r.n);
      chk("busy_after", busy, 0);
      chk("done_after", done, 0);
      start = 1'b0; valid = '0;
   endtask

   initial begin
      run_t tbl[4];
      int cnt;
      int ovc;
      tbl[0] = '{3, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hFFFF, 2, 0,
                 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, MACC + 5};
      tbl[1] = '{2, 16'hFFFF, 128'hA5A5_5A5A_0F0F_F0F0_1357_9BDF_2468_ACE0, 16'hFFFF, 0, 5,
                 128'hA5A5_5A5A_0F0F_F0F0_1357_9BDF_2468_ACE0, MACC + 3 + 5};
      tbl[2] = '{2, 16'h00FF, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h00FF, 1, 0,
                 128'h0000_0000_0000_0000_5555_6666_7777_8888, MACC + 4};
      tbl[3] = '{1, 16'h8001, 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678, 16'hFFFF, 0, 1,
                 128'hDE00_0000_0000_0000_0000_0000_0000_0078, 0};

      // Reset held 3 cycles with start asserted
      reset = 1'b1; start = 1'b1; num_pixels = 16'd5; pe_mask = 16'hFFFF;
      valid = '0; pe_ofm = '0; ofm_ready = 1'b1;
      repeat (3) step();
      chk("reset_outs", {PE_en, PE_finish, ofm_data, ofm_valid, ofm_pix, busy, done, err}, '0);
      reset = 1'b0; start = 1'b0;
      step();
      chk("idle_after_reset_busy", busy, 0);
      chk("idle_after_reset_en", PE_en, 0);

      for (int i = 0; i < 4; i++) begin
         run(tbl[i]);
         step();
      end

      // Zero-length run
      start = 1'b1; num_pixels = 16'd0; pe_mask = 16'hFFFF;
      step();
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 1);
      chk("zero_en", PE_en, 0);
      chk("zero_ovalid", ofm_valid, 0);
      step();
      chk("zero_done_clr", done, 0);
      chk("zero_idle", busy, 0);

      // Reset during MAC aborts without done
      start = 1'b1; num_pixels = 16'd2; pe_mask = 16'hFFFF;
      step();
      start = 1'b0;
      repeat (10) step();
      chk("abort_in_mac", dbg_state, 3'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_outs", {PE_en, PE_finish, ofm_data, ofm_valid, ofm_pix, busy, done, err}, '0);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (done || PE_en != '0) cnt++;
         step();
      end
      chk("abort_quiet", cnt, 0);

`ifdef SEQ_WATCHDOG_EN
      // Valid never arrives: watchdog ends the run with err
      start = 1'b1; num_pixels = 16'd2; pe_mask = 16'hFFFF; valid = '0;
      step();
      start = 1'b0;
      cnt = 0; ovc = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (PE_finish != '0) cnt++;
         if (ofm_valid) ovc++;
         step();
      end
      chk("wd_done", done, 1);
      chk("wd_finish_cycles", cnt, TMO);
      chk("wd_err", err, 1);
      chk("wd_no_word", ovc, 0);
      chk("wd_finish_dropped", PE_finish, 0);
      step();
      chk("wd_err_sticky", err, 1);
      run(tbl[3]);
`else
      ovc = 0;
      chk("err_tied", err, ovc);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_pe_sequencer.md
# conv_pe_sequencer

Synthesizable sequencer driving the PE array of the convolution sub-top: fires `PE_en`, times the MAC window, raises `PE_finish`, waits for all active PEs to report `valid`, then streams one packed OFM word per output pixel downstream. It replaces the bench-driven `PE_en`/`PE_finish` pulse train with an RTL state machine. Over that scheme it adds a parametrised PE count, a per-run PE mask for channel tails, downstream back-pressure, and an optional completion watchdog.

## Interface
Parameters:
- `NUM_PE`, 16, number of PE lanes
- `DATA_W`, 8, OFM byte width per PE
- `MAC_CYCLES`, 35, cycles between `PE_en` pulse and `PE_finish` assertion (3x3x16 MAC window)
- `PIX_CNT_W`, 16, width of pixel counter
- `TIMEOUT`, 1023, max cycles in FINISH waiting for `valid` (used only with watchdog)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  run request; sampled in IDLE only
- `num_pixels`  in  PIX_CNT_W  OFM pixels in run (56x56 = 3136); latched at start
- `pe_mask`  in  NUM_PE  active PE lanes; latched at start
- `PE_en`  out  NUM_PE  one-cycle fire pulse per pixel
- `PE_finish`  out  NUM_PE  MAC-window-complete level
- `valid`  in  NUM_PE  per-PE result ready
- `pe_ofm`  in  NUM_PE*DATA_W  PE results, lane k at bits [k*DATA_W +: DATA_W]
- `ofm_data`  out  NUM_PE*DATA_W  captured pixel word
- `ofm_valid`  out  1  ofm_data valid
- `ofm_ready`  in  1  downstream accepts
- `ofm_pix`  out  PIX_CNT_W  index of pixel on ofm_data
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle end-of-run pulse
- `err`  out  1  sticky watchdog error

## Operation
- States: IDLE, FIRE, MAC, FINISH, OUT, DONE.
- IDLE: `start`=1 latches `num_pixels`, `pe_mask`; clears pixel counter and `err`. If `num_pixels`=0 go DONE, else FIRE. `start` outside IDLE ignored.
- FIRE (1 cycle): `PE_en`=mask, `PE_finish`=0 → MAC.
- MAC: exactly MAC_CYCLES cycles, down-counter → FINISH.
- FINISH: `PE_finish`=mask. When `(valid & mask)==mask`, capture `pe_ofm` into `ofm_data` with unmasked lanes forced to 0 → OUT. Unmasked `valid` bits ignored.
- OUT: `ofm_valid`=1, `PE_finish`=0; `ofm_data`, `ofm_pix` stable until `ofm_ready`. On handshake: if `ofm_pix`==num_pixels-1 → DONE, else counter+1 → FIRE.
- DONE (1 cycle): `done`=1 → IDLE.
- `ofm_pix` is pixel counter, increments only on handshake, no wrap (bounded by num_pixels ≤ 2^PIX_CNT_W-1).
- Reset: to IDLE; every output 0 (`PE_en`, `PE_finish`, `ofm_data`, `ofm_valid`, `ofm_pix`, `busy`, `done`, `err`). Reset mid-run aborts without `done`.

## Timing
- `start` at edge 0 → `PE_en` high cycle 1, MAC cycles 2..MAC_CYCLES+1, `PE_finish` from cycle MAC_CYCLES+2.
- `valid` already high on first FINISH cycle → `ofm_valid` next cycle.
- Minimum pixel period (valid immediate, ready high): MAC_CYCLES+3 cycles between `PE_en` pulses.
- `done` one cycle after final handshake; `busy` drops with return to IDLE.
- `ofm_ready` high while `ofm_valid`=0 has no effect.

## Configuration
- `SEQ_WATCHDOG_EN` defined: FINISH counts cycles; after TIMEOUT cycles without full masked `valid`, set `err`=1 (sticky until next accepted `start` or reset), drop `PE_finish`, go DONE (`done` pulses, no OFM word emitted).
- Undefined: FINISH waits indefinitely; `err` tied 0; no counter logic.

## Test plan
- Reset held 3 cycles → all outputs 0, `busy`=0; `start` during reset ignored.
- num_pixels=3, mask=16'hFFFF, valid returned 2 cycles after `PE_finish`, ready=1 → 3 `PE_en` pulses spaced MAC_CYCLES+5; `ofm_pix` 0,1,2; ofm_data equals pe_ofm; single `done`.
- Back-pressure: ofm_ready low 5 cycles in OUT → ofm_valid, ofm_data, ofm_pix stable; no `PE_en` until handshake.
- mask=16'h00FF, upper valid held 0 → `PE_en`/`PE_finish` upper 8 bits 0, run completes, ofm_data upper 64 bits 0.
- num_pixels=0 → `done` at cycle 1, no `PE_en`, `ofm_valid` never asserted; `start` during run ignored.
- `SEQ_WATCHDOG_EN`, TIMEOUT=20, valid never → `err`=1 and `done` after 20 FINISH cycles; next `start` clears `err`; reset asserted during MAC → IDLE, no `done`.
